// File: rtl/elbeth_alu_arbiter_pkg.sv
// elbeth_alu_arbiter_pkg: shared op codes, FSM states and width defaults for the ALU arbiter
package elbeth_alu_arbiter_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF = 4;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 2;
  localparam int ALU_OR = 3;
  localparam int ALU_SLT = 5;
  typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_RESP} arb_state_t;
endpackage

// File: rtl/elbeth_alu_arbiter_alu.sv
// elbeth_alu: combinational ALU (ADD/SUB/AND/OR/signed SLT, zero for undefined op codes)
module elbeth_alu
  import elbeth_alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  always_comb
    y = op == OP_W'(ALU_ADD) ? a + b :
        op == OP_W'(ALU_SUB) ? a - b :
        op == OP_W'(ALU_AND) ? a & b :
        op == OP_W'(ALU_OR)  ? a | b :
        op == OP_W'(ALU_SLT) ? DATA_W'($signed(a) < $signed(b)) : '0;
endmodule

// File: rtl/elbeth_alu_arbiter_grant2.sv
// elbeth_arb_grant2: 2-way grant, round-robin under ELBETH_ALU_ARB_RR_EN, else fixed priority to requester 0
module elbeth_arb_grant2 (
  input  logic [1:0] req_valid,
`ifdef ELBETH_ALU_ARB_RR_EN
  input  logic       last_grant,
`endif
  output logic       gnt
);
`ifdef ELBETH_ALU_ARB_RR_EN
  always_comb gnt = &req_valid ? ~last_grant : ~req_valid[0];
`else
  always_comb gnt = ~req_valid[0];
`endif
endmodule

// File: rtl/elbeth_alu_arbiter.sv
// elbeth_alu_arbiter: shares one elbeth_alu between two valid/ready requesters; ELBETH_ALU_ARB_RR_EN selects round-robin
module elbeth_alu_arbiter
  import elbeth_alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              busy
);
  arb_state_t state;
  logic [DATA_W-1:0] a_q, b_q, alu_y;
  logic [OP_W-1:0] op_q;
  logic gnt, gnt_q;
`ifdef ELBETH_ALU_ARB_RR_EN
  logic last_grant;
  elbeth_arb_grant2 u_grant (.req_valid(req_valid), .last_grant(last_grant), .gnt(gnt));
`else
  elbeth_arb_grant2 u_grant (.req_valid(req_valid), .gnt(gnt));
`endif
  elbeth_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (.op(op_q), .a(a_q), .b(b_q), .y(alu_y));
  assign req_ready = (state == ARB_IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign busy = state != ARB_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      gnt_q <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_result <= '0;
`ifdef ELBETH_ALU_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        ARB_IDLE: if (|req_valid) begin
          a_q <= gnt ? req_a1 : req_a0;
          b_q <= gnt ? req_b1 : req_b0;
          op_q <= gnt ? req_op1 : req_op0;
          gnt_q <= gnt;
`ifdef ELBETH_ALU_ARB_RR_EN
          last_grant <= gnt;
`endif
          state <= ARB_EXEC;
        end
        ARB_EXEC: begin
          rsp_result <= alu_y;
          rsp_valid <= gnt_q ? 2'b10 : 2'b01;
          state <= ARB_RESP;
        end
        ARB_RESP: if (rsp_ready[gnt_q]) begin
          rsp_valid <= 2'b00;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_elbeth_alu_arbiter.sv
// tb_elbeth_alu_arbiter: directed and random transactions checked against a transaction-level model
module tb_elbeth_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_valid = 2'b00, req_ready, rsp_valid, rsp_ready = 2'b00;
  logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0, rsp_result;
  logic [3:0] req_op0 = '0, req_op1 = '0;
  logic busy;
  logic last_win = 1'b1;
  int checks = 0;
  int errors = 0;
  int ops[5] = '{0, 1, 2, 3, 5};
  always #5 clk = ~clk;
  elbeth_alu_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .busy(busy)
  );
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic txn(input logic [1:0] v, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                     input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1, input int hold);
    logic w;
    logic [31:0] exp;
`ifdef ELBETH_ALU_ARB_RR_EN
    w = (v == 2'b11) ? ~last_win : v[1];
`else
    w = (v == 2'b11) ? 1'b0 : v[1];
`endif
    exp = w ? alu_ref(o1, a1, b1) : alu_ref(o0, a0, b0);
    req_valid = v;
    req_op0 = o0; req_a0 = a0; req_b0 = b0;
    req_op1 = o1; req_a1 = a1; req_b1 = b1;
    #1;
    chk("req_ready_grant", 32'(req_ready), w ? 32'd2 : 32'd1);
    last_win = w;
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_a0 = ~a0; req_a1 = ~a1;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), w ? 32'd2 : 32'd1);
    chk("rsp_result", rsp_result, exp);
    for (int i = 0; i < hold; i++) begin
      req_valid = 2'b11;
      rsp_ready = w ? 2'b01 : 2'b10;
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), w ? 32'd2 : 32'd1);
      chk("hold_rsp_result", rsp_result, exp);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 2'b00;
    rsp_ready = w ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rsp_result", rsp_result, exp);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    txn(2'b01, 4'd0, 32'd3, 32'd4, 4'd0, 32'd0, 32'd0, 0);
    txn(2'b10, 4'd0, 32'd0, 32'd0, 4'd1, 32'd5, 32'd2, 0);
    txn(2'b11, 4'd3, 32'hA, 32'h5, 4'd5, 32'd3, 32'd4, 0);
    txn(2'b11, 4'd3, 32'hA, 32'h5, 4'd5, 32'd3, 32'd4, 0);
    txn(2'b10, 4'd3, 32'hA, 32'h5, 4'd5, 32'd3, 32'd4, 0);
    txn(2'b01, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 32'd0, 5);
    txn(2'b10, 4'd0, 32'd0, 32'd0, 4'd5, 32'hFFFF_FFFF, 32'd1, 1);
    req_valid = 2'b01;
    req_op0 = 4'd0; req_a0 = 32'd9; req_b0 = 32'd9;
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_win = 1'b1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_result", rsp_result, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    txn(2'b01, 4'd0, 32'd1, 32'd1, 4'd0, 32'd0, 32'd0, 0);
    txn(2'b11, 4'd2, 32'hF0F0, 32'hFF00, 4'd1, 32'd0, 32'd1, 0);
    for (int n = 0; n < 40; n++)
      txn(2'($urandom_range(1, 3)),
          4'(ops[$urandom_range(0, 4)]), $urandom, $urandom,
          4'(ops[$urandom_range(0, 4)]), $urandom, $urandom,
          int'($urandom_range(0, 3)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
